// File: rtl/apb_periph_arbiter.sv
// Two-requester round-robin arbiter in front of a single APB master port.
// Optional ACCESS-phase timeout is compiled in when APB_TIMEOUT_EN is defined.
module apb_periph_arbiter #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [1:0]                  req_i,
    input  logic [2*APB_ADDR_WIDTH-1:0] addr_i,
    input  logic [1:0]                  we_i,
    input  logic [2*APB_DATA_WIDTH-1:0] wdata_i,
    output logic [1:0]                  gnt_o,
    output logic [1:0]                  rvalid_o,
    output logic [APB_DATA_WIDTH-1:0]   rdata_o,
    output logic                        err_o,
    output logic [APB_ADDR_WIDTH-1:0]   paddr_o,
    output logic [APB_DATA_WIDTH-1:0]   pwdata_o,
    output logic                        pwrite_o,
    output logic                        psel_o,
    output logic                        penable_o,
    input  logic [APB_DATA_WIDTH-1:0]   prdata_i,
    input  logic                        pready_i,
    input  logic                        pslverr_i
);

    localparam int AW = APB_ADDR_WIDTH;
    localparam int DW = APB_DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            ptr_q, ptr_d;
    logic            owner_q, owner_d;
    logic [AW-1:0]   paddr_q, paddr_d;
    logic [DW-1:0]   pwdata_q, pwdata_d;
    logic            pwrite_q, pwrite_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [1:0]      rvalid_q, rvalid_d;
    logic [1:0]      gnt;
    logic            winner;
    logic            timeout;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d   = cnt_q;
        timeout = 1'b0;
        if (state_q == SETUP) begin
            cnt_d = '0;
        end else if (state_q == ACCESS && !pready_i) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
                timeout = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
`endif

    // The priority holder wins when requesting; otherwise the other requester does.
    assign winner = req_i[ptr_q] ? ptr_q : ~ptr_q;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pwrite_d = pwrite_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        rvalid_d = 2'b00;
        gnt      = 2'b00;

        case (state_q)
            IDLE: begin
                // Gated by reset so a requester never sees a grant that gets discarded.
                if (|req_i && !rst_i) begin
                    gnt[winner] = 1'b1;
                    paddr_d     = addr_i[(winner ? AW : 0) +: AW];
                    pwdata_d    = wdata_i[(winner ? DW : 0) +: DW];
                    pwrite_d    = we_i[winner];
                    owner_d     = winner;
                    ptr_d       = ~winner;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (pready_i) begin
                    rdata_d           = pwrite_q ? '0 : prdata_i;
                    err_d             = pslverr_i;
                    rvalid_d[owner_q] = 1'b1;
                    state_d           = IDLE;
                end else if (timeout) begin
                    rdata_d           = '0;
                    err_d             = 1'b1;
                    rvalid_d[owner_q] = 1'b1;
                    state_d           = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            ptr_q    <= 1'b0;
            owner_q  <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            rvalid_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pwrite_q <= pwrite_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            rvalid_q <= rvalid_d;
        end
    end

    // APB phase strobes decode straight from the state, so penable can never lead psel.
    assign psel_o    = (state_q != IDLE);
    assign penable_o = (state_q == ACCESS);
    assign gnt_o     = gnt;
    assign rvalid_o  = rvalid_q;
    assign rdata_o   = rdata_q;
    assign err_o     = err_q;
    assign paddr_o   = paddr_q;
    assign pwdata_o  = pwdata_q;
    assign pwrite_o  = pwrite_q;

endmodule

// File: tb/tb_apb_periph_arbiter.sv
// Directed bench for apb_periph_arbiter: grant/latency, round-robin, waited write
// with slave error, reset abort, ACCESS timeout (or its absence) and APB legality.
module tb_apb_periph_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic [1:0]    req;
    logic [2*AW-1:0] addr;
    logic [1:0]    we;
    logic [2*DW-1:0] wdata;
    logic [1:0]    gnt;
    logic [1:0]    rvalid;
    logic [DW-1:0] rdata;
    logic          err;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          pwrite;
    logic          psel;
    logic          penable;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;

    int n_cmp = 0;
    int n_mis = 0;

    logic          prev_psel   = 1'b0;
    logic [AW-1:0] prev_paddr  = '0;
    logic [DW-1:0] prev_pwdata = '0;
    logic          prev_pwrite = 1'b0;

    apb_periph_arbiter #(
        .APB_ADDR_WIDTH(AW),
        .APB_DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .req_i    (req),
        .addr_i   (addr),
        .we_i     (we),
        .wdata_i  (wdata),
        .gnt_o    (gnt),
        .rvalid_o (rvalid),
        .rdata_o  (rdata),
        .err_o    (err),
        .paddr_o  (paddr),
        .pwdata_o (pwdata),
        .pwrite_o (pwrite),
        .psel_o   (psel),
        .penable_o(penable),
        .prdata_i (prdata),
        .pready_i (pready),
        .pslverr_i(pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Per-cycle legality: strobes, grant only while idle, one-hot pulses, stable APB fields.
    task proto();
        chk("penable_without_psel", penable & ~psel, 1'b0);
        chk("gnt_outside_idle", (|gnt) & psel, 1'b0);
        chk("gnt_onehot0", $onehot0(gnt), 1'b1);
        chk("rvalid_onehot0", $onehot0(rvalid), 1'b1);
        if (prev_psel && psel) begin
            chk("paddr_stable", paddr, prev_paddr);
            chk("pwdata_stable", pwdata, prev_pwdata);
            chk("pwrite_stable", pwrite, prev_pwrite);
        end
        prev_psel   = psel;
        prev_paddr  = paddr;
        prev_pwdata = pwdata;
        prev_pwrite = pwrite;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task smp();
        @(negedge clk);
        proto();
    endtask

    initial begin
        rst     = 1'b1;
        req     = 2'b00;
        addr    = '0;
        we      = 2'b00;
        wdata   = '0;
        prdata  = '0;
        pready  = 1'b0;
        pslverr = 1'b0;

        // Reset state
        cyc(); cyc(); smp();
        chk("rst_psel", psel, 1'b0);
        chk("rst_penable", penable, 1'b0);
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_rvalid", rvalid, 2'b00);
        chk("rst_err", err, 1'b0);
        chk("rst_paddr", paddr, 32'h0);
        chk("rst_pwdata", pwdata, 32'h0);
        chk("rst_pwrite", pwrite, 1'b0);
        chk("rst_rdata", rdata, 32'h0);

        // Test 1: single read by requester 0, zero-wait
        cyc();
        rst = 1'b0; req = 2'b01; addr[31:0] = 32'h1A10_0000; we = 2'b00;
        pready = 1'b1; prdata = 32'hDEAD_BEEF;
        smp();
        chk("t1_gnt_T", gnt, 2'b01);
        chk("t1_psel_T", psel, 1'b0);
        cyc(); req = 2'b00; smp();
        chk("t1_psel_T1", psel, 1'b1);
        chk("t1_penable_T1", penable, 1'b0);
        chk("t1_paddr", paddr, 32'h1A10_0000);
        chk("t1_pwrite", pwrite, 1'b0);
        chk("t1_rvalid_T1", rvalid, 2'b00);
        cyc(); smp();
        chk("t1_psel_T2", psel, 1'b1);
        chk("t1_penable_T2", penable, 1'b1);
        chk("t1_rvalid_T2", rvalid, 2'b00);
        cyc(); smp();
        chk("t1_rvalid_T3", rvalid, 2'b01);
        chk("t1_rdata", rdata, 32'hDEAD_BEEF);
        chk("t1_err", err, 1'b0);
        chk("t1_psel_T3", psel, 1'b0);

        // Test 2: both requesting continuously, after reset -> 0,1,0,1,0 back-to-back
        cyc(); rst = 1'b1; smp();
        cyc(); rst = 1'b0;
        addr[31:0] = 32'h0000_0100; addr[63:32] = 32'h0000_0200;
        prdata = 32'h1111_1111; pready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            cyc();
            req = (c < 13) ? 2'b11 : 2'b00;
            smp();
            if (c % 3 == 0 && c < 13)
                chk("t2_gnt", gnt, ((c / 3) % 2 == 0) ? 2'b01 : 2'b10);
            else
                chk("t2_gnt", gnt, 2'b00);
            if (c % 3 == 0 && c >= 3) begin
                chk("t2_rvalid", rvalid, (((c / 3) - 1) % 2 == 0) ? 2'b01 : 2'b10);
                chk("t2_rdata", rdata, 32'h1111_1111);
            end else begin
                chk("t2_rvalid", rvalid, 2'b00);
            end
            if (c % 3 == 1)
                chk("t2_paddr", paddr, ((c / 3) % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200);
        end

        // Test 3: write by requester 1, three wait states, slave error
        cyc();
        req = 2'b10; addr[63:32] = 32'h1A10_0004; we = 2'b10; wdata[63:32] = 32'h0000_00A5;
        pready = 1'b0; pslverr = 1'b1;
        smp();
        chk("t3_gnt", gnt, 2'b10);
        cyc(); req = 2'b00; wdata[63:32] = 32'h0000_00FF; smp();
        chk("t3_psel_setup", psel, 1'b1);
        chk("t3_penable_setup", penable, 1'b0);
        chk("t3_pwdata", pwdata, 32'h0000_00A5);
        chk("t3_pwrite", pwrite, 1'b1);
        chk("t3_paddr", paddr, 32'h1A10_0004);
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (i == 3) pready = 1'b1;
            smp();
            chk("t3_penable_access", penable, 1'b1);
            chk("t3_pwdata_access", pwdata, 32'h0000_00A5);
            chk("t3_rvalid_wait", rvalid, 2'b00);
        end
        cyc(); pready = 1'b0; pslverr = 1'b0; smp();
        chk("t3_rvalid", rvalid, 2'b10);
        chk("t3_err", err, 1'b1);
        chk("t3_rdata_write", rdata, 32'h0);
        chk("t3_penable_end", penable, 1'b0);
        chk("t3_psel_end", psel, 1'b0);

        // Test 4: reset during ACCESS of requester 1
        cyc();
        req = 2'b10; addr[63:32] = 32'h0000_0300; we = 2'b00; pready = 1'b0;
        prdata = 32'h2222_2222;
        smp();
        chk("t4_gnt", gnt, 2'b10);
        cyc(); req = 2'b00; smp();
        chk("t4_psel_setup", psel, 1'b1);
        cyc(); smp();
        chk("t4_penable_access", penable, 1'b1);
        cyc(); rst = 1'b1; pready = 1'b1; smp();
        chk("t4_penable_in_rst_cycle", penable, 1'b1);
        cyc();
        rst = 1'b0; req = 2'b11; addr[31:0] = 32'h0000_0500;
        smp();
        chk("t4_psel_after_rst", psel, 1'b0);
        chk("t4_penable_after_rst", penable, 1'b0);
        chk("t4_no_rvalid", rvalid, 2'b00);
        chk("t4_err_cleared", err, 1'b0);
        chk("t4_gnt_req0_first", gnt, 2'b01);
        cyc(); req = 2'b00; smp();
        chk("t4_paddr", paddr, 32'h0000_0500);
        cyc(); smp();
        cyc(); smp();
        chk("t4_rvalid", rvalid, 2'b01);
        chk("t4_rdata", rdata, 32'h2222_2222);

        // Test 5: slave never ready
        cyc();
        req = 2'b01; addr[31:0] = 32'h0000_0400; pready = 1'b0; prdata = 32'hFFFF_FFFF;
        smp();
        chk("t5_gnt", gnt, 2'b01);
        cyc(); req = 2'b00; smp();
        chk("t5_setup", {psel, penable}, 2'b10);
`ifdef APB_TIMEOUT_EN
        for (int i = 0; i < 8; i++) begin
            cyc(); smp();
            chk("t5_access", {psel, penable}, 2'b11);
            chk("t5_rvalid_wait", rvalid, 2'b00);
        end
        cyc(); smp();
        chk("t5_to_rvalid", rvalid, 2'b01);
        chk("t5_to_err", err, 1'b1);
        chk("t5_to_rdata", rdata, 32'h0);
        chk("t5_to_psel", psel, 1'b0);
        cyc(); smp();
        chk("t5_idle_after", {psel, penable, rvalid}, 4'b0000);
`else
        for (int i = 0; i < 100; i++) begin
            cyc(); smp();
            chk("t5_still_access", {psel, penable}, 2'b11);
            chk("t5_no_rvalid", rvalid, 2'b00);
        end
        cyc(); rst = 1'b1; smp();
        cyc(); rst = 1'b0; smp();
        chk("t5_psel_after_rst", psel, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
